// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
package pc_gen_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   // Tag holds the full word address; the index bits always match the slot, so this stays direct-mapped.
   typedef struct packed {
      logic            valid;
      logic [PC_W-3:0] tag;
      logic [PC_W-1:0] target;
   } btb_entry_t;

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC, one update port.
// Only compiled into pc_gen when PC_GEN_BTB_EN is defined.
module pc_gen_btb
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lookup_pc_i,
   output logic            hit_c,
   output logic [XLEN-1:0] target_c,
   input  logic            upd_valid_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic [XLEN-1:0] upd_target_i
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   btb_entry_t       entries_q [DEPTH];
   btb_entry_t       entries_d [DEPTH];
   btb_entry_t       lookup_entry;
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] upd_idx;
   logic             unused_lsb;

   assign lookup_idx   = lookup_pc_i[2 +: IDX_W];
   assign upd_idx      = upd_pc_i[2 +: IDX_W];
   assign unused_lsb   = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

   // Lookup reads registered contents, so a same-cycle update is seen only from the next cycle.
   assign lookup_entry = entries_q[lookup_idx];
   assign hit_c        = lookup_entry.valid &&
                         (lookup_entry.tag == (PC_W-2)'(lookup_pc_i[XLEN-1:2]));
   assign target_c     = XLEN'(lookup_entry.target);

   always_comb begin
      entries_d = entries_q;
      if (upd_valid_i) begin
         entries_d[upd_idx].valid = upd_taken_i;
         if (upd_taken_i) begin
            entries_d[upd_idx].tag    = (PC_W-2)'(upd_pc_i[XLEN-1:2]);
            entries_d[upd_idx].target = PC_W'(upd_target_i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entries_q <= '{default: '0};
      end else begin
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing with trap, redirect and sequential next PC.
// Define PC_GEN_BTB_EN to add branch target prediction of the sequential PC.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000),
   parameter int unsigned     BTB_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_ready_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            upd_valid_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic [XLEN-1:0] upd_target_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            pred_taken_o,
   output logic            misalign_o
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            misalign_q, misalign_d;
   logic            btb_hit;
   logic [XLEN-1:0] btb_target;
   logic            pred_taken;
   logic            accept;
   logic [XLEN-1:0] seq_pc;
   logic            unused_trap_lsb;

`ifdef PC_GEN_BTB_EN
   pc_gen_btb #(
      .XLEN  (XLEN),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk          (clk),
      .rst          (rst),
      .lookup_pc_i  (pc_q),
      .hit_c        (btb_hit),
      .target_c     (btb_target),
      .upd_valid_i  (upd_valid_i),
      .upd_taken_i  (upd_taken_i),
      .upd_pc_i     (upd_pc_i),
      .upd_target_i (upd_target_i)
   );
`else
   logic unused_upd;
   assign unused_upd = ^{upd_valid_i, upd_taken_i, upd_pc_i, upd_target_i};
   assign btb_hit    = 1'b0;
   assign btb_target = '0;
`endif

   assign unused_trap_lsb = ^trap_pc_i[1:0];
   assign pred_taken      = btb_hit & pc_valid_q;
   assign accept          = if_ready_i & pc_valid_q;
   assign seq_pc          = pred_taken ? btb_target : pc_q + XLEN'(PC_STEP);

   // Next-PC priority: trap, redirect (ignored in HALT), accept, hold.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (trap_valid_i) begin
         pc_d    = {trap_pc_i[XLEN-1:2], 2'b00};
         state_d = RUN;
      end else if (redirect_valid_i && (state_q != HALT)) begin
         if (redirect_pc_i[1:0] == 2'b00) begin
            pc_d    = redirect_pc_i;
            state_d = RUN;
         end else begin
            state_d = HALT;
         end
      end else if (accept) begin
         pc_d = seq_pc;
      end else if (state_q == BOOT) begin
         state_d = RUN;
      end
      pc_valid_d = (state_d == RUN);
      misalign_d = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o         = pc_q;
   assign pc_valid_o   = pc_valid_q;
   assign pred_taken_o = pred_taken;
   assign misalign_o   = misalign_q;

endmodule
